// File: rtl/freq_key_ctrl.sv
// Front-panel key controller: debounces four keys, edits two wrapped frequency settings
// and commits them through a req/ack handshake. Define AUTO_REPEAT_EN for held-key repeat.
module freq_key_ctrl #(
    parameter int unsigned DEB_CNT     = 1_000_000,
    parameter int unsigned FREQ_MIN    = 1,
    parameter int unsigned FREQ_MAX    = 99,
    parameter int unsigned FREQ_A_INIT = 10,
    parameter int unsigned FREQ_B_INIT = 20,
    parameter int unsigned ACK_TIMEOUT = 65535
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        key_sel,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_wr,
    input  logic        wr_ack,
    output logic        wr_req,
    output logic [15:0] wr_data,
    output logic [7:0]  freq_a,
    output logic [7:0]  freq_b,
    output logic        sel,
    output logic [3:0]  wr_stat
);
    // state | meaning
    // IDLE  | editing allowed, waiting for key_wr
    // REQ   | wr_req held, waiting for wr_ack or timeout
    // DONE  | commit acknowledged, status 1
    // ERR   | commit timed out, status 3
    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    localparam int unsigned DEB_W = $clog2(DEB_CNT + 1);
    localparam int unsigned TO_W  = $clog2(ACK_TIMEOUT + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

    state_t state, state_nxt;

    logic [3:0] key_raw, sync1, sync2, sync_d, deb, deb_d, press;
    logic [DEB_W-1:0] deb_cnt [4];
    logic [TO_W-1:0]  to_cnt;
    logic step_up, step_down;

    // bit order: 0 sel, 1 up, 2 down, 3 wr
    assign key_raw = {key_wr, key_down, key_up, key_sel};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1  <= 4'hF;
            sync2  <= 4'hF;
            sync_d <= 4'hF;
            deb    <= 4'hF;
            deb_d  <= 4'hF;
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            sync1  <= key_raw;
            sync2  <= sync1;
            sync_d <= sync2;
            deb_d  <= deb;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != sync_d[i])
                    deb_cnt[i] <= '0;
                else if (deb_cnt[i] == DEB_LAST)
                    deb[i] <= sync_d[i];
                else
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
        end
    end

    assign press = deb_d & ~deb;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned REP_W = 25;
    localparam logic [REP_W-1:0] REP_HOLD_LAST = REP_W'(25_000_000 - 1);
    localparam logic [REP_W-1:0] REP_RATE_LAST = REP_W'(5_000_000 - 1);

    logic [REP_W-1:0] rep_cnt [2];
    logic [1:0] rep_armed, rep_pulse;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rep_armed <= '0;
            rep_pulse <= '0;
            for (int i = 0; i < 2; i++) rep_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                rep_pulse[i] <= 1'b0;
                if (deb[i+1] || state != IDLE) begin
                    rep_cnt[i]   <= '0;
                    rep_armed[i] <= 1'b0;
                end else if ((!rep_armed[i] && rep_cnt[i] == REP_HOLD_LAST) ||
                             (rep_armed[i] && rep_cnt[i] == REP_RATE_LAST)) begin
                    rep_cnt[i]   <= '0;
                    rep_armed[i] <= 1'b1;
                    rep_pulse[i] <= 1'b1;
                end else begin
                    rep_cnt[i] <= rep_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign step_up   = press[1] | rep_pulse[0];
    assign step_down = press[2] | rep_pulse[1];
`else
    assign step_up   = press[1];
    assign step_down = press[2];
`endif

    function automatic logic [7:0] f_step(input logic [7:0] f, input logic up);
        if (up) return (f >= 8'(FREQ_MAX)) ? 8'(FREQ_MIN) : f + 8'd1;
        else    return (f <= 8'(FREQ_MIN)) ? 8'(FREQ_MAX) : f - 8'd1;
    endfunction

    // sel is sampled before its own toggle, so a coincident step edits the old channel
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            freq_a <= 8'(FREQ_A_INIT);
            freq_b <= 8'(FREQ_B_INIT);
            sel    <= 1'b0;
        end else begin
            if (press[0]) sel <= ~sel;
            if (state == IDLE && (step_up ^ step_down)) begin
                if (!sel) freq_a <= f_step(freq_a, step_up);
                else      freq_b <= f_step(freq_b, step_up);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (press[3]) state_nxt = REQ;
            REQ: begin
                if (wr_ack)                 state_nxt = DONE;
                else if (to_cnt == TO_LAST) state_nxt = ERR;
            end
            DONE: state_nxt = IDLE;
            ERR:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign wr_req = (state == REQ);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            to_cnt  <= '0;
            wr_data <= '0;
            wr_stat <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (press[3]) begin
                        wr_data <= {freq_a, freq_b};
                        to_cnt  <= '0;
                        wr_stat <= 4'd2;
                    end else if (step_up ^ step_down) begin
                        wr_stat <= 4'd0;
                    end
                end
                REQ: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (wr_ack)                 wr_stat <= 4'd1;
                    else if (to_cnt == TO_LAST) wr_stat <= 4'd3;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/freq_key_ctrl.md
Name: freq_key_ctrl

Overview:
Front-panel controller that turns four raw push-buttons into the two wave-frequency settings (0..99 units) and a write-status digit. It feeds the 5-digit seven-segment driver: freq_a drives digits 1-0, freq_b drives digits 3-2, and wr_stat drives digit 4. It also runs a req/ack handshake that commits the settings to the downstream waveform generator.

Parameters:
DEB_CNT, 1_000_000, stable cycles required to accept a key level (20 ms at 50 MHz)
FREQ_MIN, 1, lowest legal frequency value
FREQ_MAX, 99, highest legal frequency value (must be <= 99)
FREQ_A_INIT, 10, freq_a reset value
FREQ_B_INIT, 20, freq_b reset value
ACK_TIMEOUT, 65535, cycles to wait for wr_ack before flagging an error

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst_n  in  1  reset; asynchronous, active-low
key_sel  in  1  raw key, active-low; toggles the edited channel
key_up  in  1  raw key, active-low; increments the selected frequency
key_down  in  1  raw key, active-low; decrements the selected frequency
key_wr  in  1  raw key, active-low; commits the settings
wr_ack  in  1  acknowledge from the waveform generator, active-high
wr_req  out  1  commit request, active-high
wr_data  out  16  {freq_a, freq_b}, latched at commit
freq_a  out  8  channel A setting, to display num1
freq_b  out  8  channel B setting, to display num2
sel  out  1  0 = editing A, 1 = editing B
wr_stat  out  4  status digit, to display num3

Behaviour:
- Reset values: freq_a=FREQ_A_INIT, freq_b=FREQ_B_INIT, sel=0, wr_req=0, wr_data=0, wr_stat=0; debounced key levels=1; FSM=IDLE.
- Per key: 2-flop synchroniser, then a debounce counter that clears on any change of the synced level. When the counter reaches DEB_CNT-1 with the level unchanged, that level is loaded into the debounced register.
- A press pulse is a 1-cycle pulse on the 1->0 edge of the debounced level. Release generates no event.
- key_sel press: sel toggles, at any FSM state.
- key_up press (IDLE only): selected channel +1. At FREQ_MAX it wraps to FREQ_MIN.
- key_down press (IDLE only): selected channel -1. At FREQ_MIN it wraps to FREQ_MAX.
- up and down pulses in the same cycle: no change.
- An up/down pulse arriving in the same cycle as a sel pulse acts on the old sel.
- Any value change sets wr_stat=0 (dirty).
- Frequency registers update 1 cycle after the press pulse.
- wr_stat codes: 0 = dirty/never written, 1 = written OK, 2 = busy, 3 = timeout.
- FSM states:
  - IDLE: on a key_wr pulse, latch wr_data={freq_a,freq_b}, set wr_req=1, wr_stat=2, clear the timeout counter, go to REQ (wr_req visible next cycle).
  - REQ: hold wr_req and wr_data stable; count cycles. If wr_ack=1 is sampled, go to DONE (ack wins when it coincides with timeout). If the counter reaches ACK_TIMEOUT-1 without ack, go to ERR.
  - DONE: wr_req=0, wr_stat=1, return to IDLE next cycle.
  - ERR: wr_req=0, wr_stat=3, return to IDLE next cycle.
- key_wr, up and down pulses outside IDLE are dropped, not queued.
- wr_ack while in IDLE is ignored.
- Asserting reset mid-handshake drops wr_req immediately and restores all reset values.
- Arithmetic is 8-bit unsigned. Outputs never leave the range [FREQ_MIN, FREQ_MAX].

Optional Feature:
AUTO_REPEAT_EN
- Defined: holding key_up or key_down (debounced low, in IDLE) for 25_000_000 cycles (0.5 s) generates an extra step pulse, then one every 5_000_000 cycles (0.1 s) until release. Repeat pulses follow the same wrap rules.
- Undefined: one step per press only; the repeat counters are not built.

Test Plan:
- Reset released, no keys -> freq_a=10, freq_b=20, sel=0, wr_stat=0, wr_req=0.
- Bench DEB_CNT=16: key_up low with 5-cycle bounces, then stable 40 cycles -> exactly one increment, freq_a 10->11, wr_stat=0; a 10-cycle glitch alone -> no change.
- sel=1, freq_b=99, key_up press -> freq_b=1. Then key_down press -> freq_b=99. freq_a unchanged.
- key_wr press, wr_ack high 5 cycles after wr_req rises -> wr_data=16'h0B63 (11,99), wr_stat=2 then 1, wr_req drops the cycle after ack is sampled.
- ACK_TIMEOUT=32, key_wr press, wr_ack held 0 -> wr_req high 32 cycles then 0, wr_stat=3. key_up presses pressed during REQ -> ignored.
- Reset asserted mid-REQ -> wr_req=0 asynchronously; after release, freq_a=10, freq_b=20, wr_stat=0.
